// File: rtl/peak_result_reader.sv
// peak_result_reader: captures the packed per-pixel peak-result word on the
// frame-done strobe and streams it one pixel per valid/ready transfer.
// One extra frame can be queued while the current one drains.
// Optional build macro PEAK_READER_CHECKSUM_EN appends an XOR trailer word
// (out_pixel = PIXELS) after the last pixel and moves out_last onto it.
module peak_result_reader #(
  parameter int NP     = 16,
  parameter int PIXELS = 4,
  parameter int PW     = 3
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic                 frame_done,
  input  logic [NP*PIXELS-1:0] result,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NP-1:0]        out_data,
  output logic [PW-1:0]        out_pixel,
  output logic                 out_last,
  output logic                 busy,
  output logic                 overrun
);

  typedef enum logic {IDLE, STREAM} state_t;

`ifdef PEAK_READER_CHECKSUM_EN
  localparam int LAST = PIXELS;
`else
  localparam int LAST = PIXELS - 1;
`endif
  localparam logic [PW-1:0] LAST_IDX = PW'(LAST);

  state_t               state_q, state_d;
  logic [PW-1:0]        idx_q, idx_d;
  logic [NP*PIXELS-1:0] shadow_q, shadow_d;
  logic [NP*PIXELS-1:0] pend_q, pend_d;
  logic                 pend_full_q, pend_full_d;
  logic                 overrun_q, overrun_d;

  logic accept;
  logic last_accept;

  // Select pixel word i from a packed frame; out-of-range indices give zero.
  function automatic logic [NP-1:0] pick_word(input logic [NP*PIXELS-1:0] w,
                                              input logic [PW-1:0] i);
    logic [NP-1:0] r;
    r = '0;
    for (int k = 0; k < PIXELS; k++) begin
      if (i == PW'(k)) r = w[k*NP +: NP];
    end
    return r;
  endfunction

  // XOR of every pixel word in a packed frame.
  function automatic logic [NP-1:0] xor_words(input logic [NP*PIXELS-1:0] w);
    logic [NP-1:0] r;
    r = '0;
    for (int k = 0; k < PIXELS; k++) begin
      r = r ^ w[k*NP +: NP];
    end
    return r;
  endfunction

  // Output view of the shadow frame at the current index.
  always_comb begin
    out_valid = (state_q == STREAM);
    out_pixel = idx_q;
    out_last  = out_valid && (idx_q == LAST_IDX);
    out_data  = pick_word(shadow_q, idx_q);
`ifdef PEAK_READER_CHECKSUM_EN
    if (idx_q == PW'(PIXELS)) out_data = xor_words(shadow_q);
`endif
    busy      = (state_q == STREAM) || pend_full_q;
    overrun   = overrun_q;
  end

  assign accept      = out_valid && out_ready;
  assign last_accept = accept && (idx_q == LAST_IDX);

  // Next-state: frame capture, index advance, pending queue and overrun.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    shadow_d    = shadow_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    overrun_d   = overrun_q;
    unique case (state_q)
      IDLE: begin
        if (frame_done) begin
          shadow_d = result;
          idx_d    = '0;
          state_d  = STREAM;
        end
      end
      STREAM: begin
        if (last_accept) begin
          idx_d = '0;
          if (pend_full_q) begin
            // Queued frame moves up; a simultaneous strobe refills the queue.
            shadow_d = pend_q;
            if (frame_done) pend_d = result;
            else            pend_full_d = 1'b0;
          end else if (frame_done) begin
            shadow_d = result;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (accept) idx_d = idx_q + PW'(1);
          if (frame_done) begin
            if (!pend_full_q) begin
              pend_d      = result;
              pend_full_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and storage registers; reset empties both frame buffers.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      shadow_q    <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      overrun_q   <= overrun_d;
    end
  end

endmodule

// File: tb/tb_peak_result_reader.sv
// Directed bench for peak_result_reader: single frame, backpressure,
// pending frame, strobes on the last accept, overrun and mid-stream reset.
module tb_peak_result_reader;

  localparam int NP     = 16;
  localparam int PIXELS = 4;
  localparam int PW     = 3;
`ifdef PEAK_READER_CHECKSUM_EN
  localparam int LAST = PIXELS;
`else
  localparam int LAST = PIXELS - 1;
`endif

  logic                 clk = 1'b0;
  logic                 res = 1'b0;
  logic                 frame_done = 1'b0;
  logic [NP*PIXELS-1:0] result = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [NP-1:0]        out_data;
  logic [PW-1:0]        out_pixel;
  logic                 out_last;
  logic                 busy;
  logic                 overrun;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [63:0] FA = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
  localparam logic [63:0] FB = {16'hBBBB, 16'hBBBB, 16'hBBBB, 16'hBBBB};
  localparam logic [63:0] FC = {16'hC0DE, 16'h00F0, 16'h1234, 16'hA5A5};
  localparam logic [63:0] FD = {16'h8000, 16'h0001, 16'hFFFF, 16'h7FFE};

  peak_result_reader #(.NP(NP), .PIXELS(PIXELS), .PW(PW)) dut (
    .clk(clk), .res(res), .frame_done(frame_done), .result(result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_pixel(out_pixel), .out_last(out_last), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_word(input string tag, input logic [15:0] d, input int pix, input bit last);
    chk({tag, " valid"}, 32'(out_valid), 32'd1);
    chk({tag, " data"},  32'(out_data),  32'(d));
    chk({tag, " pixel"}, 32'(out_pixel), 32'(pix));
    chk({tag, " last"},  32'(out_last),  32'(last));
  endtask

  // Accept words start..LAST of frame w with ready high; optionally strobe
  // nxt on the final accept cycle.
  task automatic drain(input string tag, input logic [63:0] w, input int start,
                       input bit inj, input logic [63:0] nxt);
    logic [15:0] x;
    logic [15:0] e;
    x = '0;
    for (int k = 0; k < PIXELS; k++) x = x ^ w[k*16 +: 16];
    out_ready = 1'b1;
    for (int k = start; k <= LAST; k++) begin
      e = (k < PIXELS) ? w[k*16 +: 16] : x;
      expect_word($sformatf("%s w%0d", tag, k), e, k, k == LAST);
      if (inj && k == LAST) begin
        frame_done = 1'b1;
        result     = nxt;
      end
      tick();
      frame_done = 1'b0;
    end
  endtask

  task automatic strobe(input logic [63:0] w);
    result     = w;
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
  endtask

  task automatic do_reset();
    res = 1'b1;
    tick();
    res = 1'b0;
  endtask

  initial begin
    #2;
    do_reset();
    chk("rst valid",   32'(out_valid), 32'd0);
    chk("rst busy",    32'(busy),      32'd0);
    chk("rst overrun", 32'(overrun),   32'd0);
    chk("rst data",    32'(out_data),  32'd0);
    chk("rst pixel",   32'(out_pixel), 32'd0);
    chk("rst last",    32'(out_last),  32'd0);

    // Single frame, ready always high; first word one cycle after the strobe.
    out_ready = 1'b1;
    result = FA;
    frame_done = 1'b1;
    chk("single pre valid", 32'(out_valid), 32'd0);
    tick();
    frame_done = 1'b0;
    drain("single", FA, 0, 1'b0, '0);
    chk("single end valid", 32'(out_valid), 32'd0);
    chk("single end busy",  32'(busy),      32'd0);
`ifdef PEAK_READER_CHECKSUM_EN
    // Hand value: 0001^0002^0003^0004 = 0004, checked through drain above.
`endif

    // Backpressure: word 0 holds for three cycles, then the frame completes.
    out_ready = 1'b0;
    strobe(FA);
    for (int c = 0; c < 3; c++) begin
      expect_word($sformatf("bp hold%0d", c), 16'h0001, 0, 1'b0);
      tick();
    end
    drain("bp", FA, 0, 1'b0, '0);
    chk("bp end valid", 32'(out_valid), 32'd0);

    // Pending frame B strobed while A streams; B follows without a gap.
    out_ready = 1'b1;
    strobe(FA);
    expect_word("pend a0", 16'h0001, 0, 1'b0);
    tick();
    expect_word("pend a1", 16'h0002, 1, 1'b0);
    result = FB;
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    chk("pend busy", 32'(busy), 32'd1);
    drain("pend A", FA, 2, 1'b0, '0);
    drain("pend B", FB, 0, 1'b0, '0);
    chk("pend overrun", 32'(overrun), 32'd0);
    chk("pend idle",    32'(out_valid), 32'd0);
    chk("pend busy0",   32'(busy),      32'd0);

    // Strobe on the last accept with nothing pending loads directly.
    strobe(FA);
    drain("direct A", FA, 0, 1'b1, FC);
    drain("direct C", FC, 0, 1'b0, '0);
    chk("direct idle", 32'(out_valid), 32'd0);

    // Strobe on the last accept with a frame pending: queue shifts, no drop.
    strobe(FA);
    expect_word("shift a0", 16'h0001, 0, 1'b0);
    result = FB;
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    drain("shift A", FA, 1, 1'b1, FD);
    chk("shift busy", 32'(busy), 32'd1);
    drain("shift B", FB, 0, 1'b0, '0);
    drain("shift D", FD, 0, 1'b0, '0);
    chk("shift overrun", 32'(overrun), 32'd0);
    chk("shift idle",    32'(out_valid), 32'd0);

    // Overrun: three back-to-back strobes while stalled; the third is dropped.
    out_ready = 1'b0;
    result = FA;
    frame_done = 1'b1;
    tick();
    result = FC;
    tick();
    chk("ovr before", 32'(overrun), 32'd0);
    result = FD;
    tick();
    frame_done = 1'b0;
    chk("ovr set", 32'(overrun), 32'd1);
    drain("ovr F1", FA, 0, 1'b0, '0);
    drain("ovr F2", FC, 0, 1'b0, '0);
    chk("ovr idle",   32'(out_valid), 32'd0);
    chk("ovr sticky", 32'(overrun),   32'd1);
    do_reset();
    chk("ovr cleared", 32'(overrun), 32'd0);

    // Reset mid-stream with a pending frame discards everything.
    out_ready = 1'b1;
    strobe(FA);
    out_ready = 1'b0;
    strobe(FB);
    chk("mid busy", 32'(busy), 32'd1);
    do_reset();
    chk("mid valid",   32'(out_valid), 32'd0);
    chk("mid busy0",   32'(busy),      32'd0);
    chk("mid overrun", 32'(overrun),   32'd0);
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("mid quiet%0d", c), 32'(out_valid), 32'd0);
      tick();
    end
    strobe(FC);
    drain("post rst", FC, 0, 1'b0, '0);
    chk("post idle", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
